// File: rtl/xge_pkg.sv
// xge_pkg: shared types and helpers for the 10GE RX packet drain.
//   state_t      - drain FSM states
//   FLAG_*       - bit positions inside the 5-bit summary flag vector
//   rx_summary_t - per-frame summary {len, xor signature, flags}
//   byte_mask()  - keep mask for an eop word given pkt_rx_mod
//   sat_len()    - clamp a 15-bit length into the 14-bit summary field
package xge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned FLAG_MAC_ERR   = 0;
    localparam int unsigned FLAG_RUNT      = 1;
    localparam int unsigned FLAG_GIANT     = 2;
    localparam int unsigned FLAG_FRAME_ERR = 3;
    localparam int unsigned FLAG_TIMEOUT   = 4;
    localparam int unsigned NUM_FLAGS      = 5;

    localparam int unsigned LEN_W   = 14;
    localparam int unsigned WORDS_W = 11;
    localparam logic [WORDS_W-1:0] WORDS_MAX = '1;

    typedef struct packed {
        logic [LEN_W-1:0]     len;
        logic [63:0]          xor_sig;
        logic [NUM_FLAGS-1:0] flags;
    } rx_summary_t;

    // Byte 0 lives in [63:56], so valid bytes are the most significant ones.
    // mod==0 means all eight bytes are valid.
    function automatic logic [63:0] byte_mask(input logic [2:0] mod);
        logic [5:0] sh;
        sh = {3'd0 - mod, 3'b000};   // (8 - mod) * 8 for mod 1..7
        if (mod == 3'd0) byte_mask = '1;
        else             byte_mask = {64{1'b1}} << sh;
    endfunction

    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W:0] v);
        sat_len = v[LEN_W] ? '1 : v[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/pkt_rx_accum.sv
// pkt_rx_accum: per-frame word counter, XOR signature and length arithmetic.
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_clear       - zero all accumulated state (start of a read burst)
//   i_word        - accumulate i_data this cycle
//   i_sop         - this word starts a frame (restarts count and XOR)
//   i_eop         - this word ends a frame; mask with i_mod and latch length
//   i_timeout     - frame aborted; latch length as words*8
//   i_data, i_mod - frame word and eop byte count (0 means 8)
//   o_len         - latched frame length in bytes (saturated)
//   o_xor         - running XOR signature
module pkt_rx_accum
    import xge_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_word,
    input  logic              i_sop,
    input  logic              i_eop,
    input  logic              i_timeout,
    input  logic [63:0]       i_data,
    input  logic [2:0]        i_mod,
    output logic [LEN_W-1:0]  o_len,
    output logic [63:0]       o_xor
);

    logic [WORDS_W-1:0] r_words;
    logic [63:0]        r_xor;
    logic [LEN_W-1:0]   r_len;

    logic [WORDS_W-1:0] w_words_base;
    logic [WORDS_W-1:0] w_words_next;
    logic [63:0]        w_xor_base;
    logic [63:0]        w_keep;
    logic [3:0]         w_last_bytes;
    logic [LEN_W:0]     w_eop_len;
    logic [LEN_W:0]     w_to_len;

    always_comb begin
        w_words_base = i_sop ? '0 : r_words;
        w_words_next = (w_words_base == WORDS_MAX) ? WORDS_MAX
                                                   : w_words_base + 11'd1;
        w_xor_base   = i_sop ? '0 : r_xor;
        w_keep       = i_eop ? byte_mask(i_mod) : '1;
        w_last_bytes = (i_mod == 3'd0) ? 4'd8 : {1'b0, i_mod};
        // Length uses the count including the eop word itself.
        w_eop_len    = {1'b0, w_words_next - 11'd1, 3'b000} + {11'd0, w_last_bytes};
        w_to_len     = {1'b0, r_words, 3'b000};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_words <= '0;
            r_xor   <= '0;
            r_len   <= '0;
        end else begin
            if (i_word) begin
                r_words <= w_words_next;
                r_xor   <= w_xor_base ^ (i_data & w_keep);
                if (i_eop) r_len <= sat_len(w_eop_len);
            end
            if (i_timeout) r_len <= sat_len(w_to_len);
        end
    end

    assign o_len = r_len;
    assign o_xor = r_xor;

endmodule

// File: rtl/pkt_rx_drain.sv
// pkt_rx_drain: 10GE MAC RX packet-interface consumer / self-checking sink.
//   clk_156m25, reset_156m25 - clock and synchronous active-high reset
//   pkt_rx_avail             - MAC holds at least one complete frame
//   pkt_rx_ren               - registered read enable to the MAC
//   pkt_rx_val/sop/eop/err   - MAC word qualifiers
//   pkt_rx_data, pkt_rx_mod  - frame word (byte 0 in [63:56]), eop byte count
//   sum_valid/sum_ready      - per-frame summary handshake
//   sum_len/sum_xor/sum_flags- summary {len, XOR signature, {to,ferr,giant,runt,mac}}
//   cnt_frames/cnt_bad       - wrapping counts of summaries / flagged summaries
module pkt_rx_drain
    import xge_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 1518,
    parameter int unsigned MIN_BYTES = 64,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25,
    input  logic        pkt_rx_avail,
    output logic        pkt_rx_ren,
    input  logic        pkt_rx_val,
    input  logic        pkt_rx_sop,
    input  logic        pkt_rx_eop,
    input  logic        pkt_rx_err,
    input  logic [63:0] pkt_rx_data,
    input  logic [2:0]  pkt_rx_mod,
    output logic        sum_valid,
    input  logic        sum_ready,
    output logic [13:0] sum_len,
    output logic [63:0] sum_xor,
    output logic [4:0]  sum_flags,
    output logic [31:0] cnt_frames,
    output logic [31:0] cnt_bad
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            r_state, w_state_next;
    logic              r_ren, w_ren_next;
    logic              r_in_frame;
    logic              r_frame_err;
    logic              r_mac_err;
    logic              r_timeout;
    logic [TO_W-1:0]   r_to_cnt;
    rx_summary_t       r_sum;
    logic              r_sum_valid;
    logic [31:0]       r_cnt_frames;
    logic [31:0]       r_cnt_bad;

    logic              w_in_read;
    logic              w_acc_word;
    logic              w_eop_hit;
    logic              w_to_hit;
    logic              w_restart;
    logic              w_discard;
    logic              w_acc_clear;
    logic [LEN_W-1:0]  w_acc_len;
    logic [63:0]       w_acc_xor;
    logic [NUM_FLAGS-1:0] w_flags;

    // Word qualifiers only matter while reading; anything else is ignored.
    always_comb begin
        w_in_read  = (r_state == ST_READ);
        w_acc_word = w_in_read && pkt_rx_val && (pkt_rx_sop || r_in_frame);
        w_eop_hit  = w_acc_word && pkt_rx_eop;
        w_to_hit   = w_in_read && !pkt_rx_val && (r_to_cnt == TO_LAST);
        w_restart  = w_in_read && pkt_rx_val && pkt_rx_sop && r_in_frame;
        w_discard  = w_in_read && pkt_rx_val && !pkt_rx_sop && !r_in_frame;
    end

    always_comb begin
        w_state_next = r_state;
        w_ren_next   = r_ren;
        w_acc_clear  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ren_next = 1'b0;
                if (pkt_rx_avail && !r_sum_valid) begin
                    w_ren_next   = 1'b1;
                    w_acc_clear  = 1'b1;
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                w_ren_next = 1'b1;
                if (w_eop_hit || w_to_hit) begin
                    w_ren_next   = 1'b0;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_ren_next   = 1'b0;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_ren_next   = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            r_state <= ST_IDLE;
            r_ren   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ren   <= w_ren_next;
        end
    end

    pkt_rx_accum u_accum (
        .i_clk     (clk_156m25),
        .i_rst     (reset_156m25),
        .i_clear   (w_acc_clear),
        .i_word    (w_acc_word),
        .i_sop     (pkt_rx_sop),
        .i_eop     (pkt_rx_eop),
        .i_timeout (w_to_hit),
        .i_data    (pkt_rx_data),
        .i_mod     (pkt_rx_mod),
        .o_len     (w_acc_len),
        .o_xor     (w_acc_xor)
    );

    // Frame tracking and error latches; error latches survive until the
    // summary that reports them is loaded.
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            r_in_frame  <= 1'b0;
            r_frame_err <= 1'b0;
            r_mac_err   <= 1'b0;
            r_timeout   <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            if (!w_in_read)                    r_in_frame <= 1'b0;
            else if (w_eop_hit || w_to_hit)    r_in_frame <= 1'b0;
            else if (pkt_rx_val && pkt_rx_sop) r_in_frame <= 1'b1;

            if (!w_in_read || pkt_rx_val) r_to_cnt <= '0;
            else if (!w_to_hit)           r_to_cnt <= r_to_cnt + 1'b1;

            if (r_state == ST_DONE) begin
                r_frame_err <= 1'b0;
                r_mac_err   <= 1'b0;
                r_timeout   <= 1'b0;
            end else begin
                if (w_restart || w_discard || w_to_hit) r_frame_err <= 1'b1;
                if (w_eop_hit) r_mac_err <= pkt_rx_err;
                if (w_to_hit)  r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_flags                 = '0;
        w_flags[FLAG_MAC_ERR]   = r_mac_err;
        w_flags[FLAG_RUNT]      = (w_acc_len < LEN_W'(MIN_BYTES));
        w_flags[FLAG_GIANT]     = (w_acc_len > LEN_W'(MAX_BYTES));
        w_flags[FLAG_FRAME_ERR] = r_frame_err;
        w_flags[FLAG_TIMEOUT]   = r_timeout;
    end

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            r_sum        <= '0;
            r_sum_valid  <= 1'b0;
            r_cnt_frames <= '0;
            r_cnt_bad    <= '0;
        end else if (r_state == ST_DONE) begin
            r_sum.len     <= w_acc_len;
            r_sum.xor_sig <= w_acc_xor;
            r_sum.flags   <= w_flags;
            r_sum_valid   <= 1'b1;
            r_cnt_frames  <= r_cnt_frames + 32'd1;
            if (|w_flags) r_cnt_bad <= r_cnt_bad + 32'd1;
        end else if (r_sum_valid && sum_ready) begin
            r_sum_valid <= 1'b0;
        end
    end

    assign pkt_rx_ren = r_ren;
    assign sum_valid  = r_sum_valid;
    assign sum_len    = r_sum.len;
    assign sum_xor    = r_sum.xor_sig;
    assign sum_flags  = r_sum.flags;
    assign cnt_frames = r_cnt_frames;
    assign cnt_bad    = r_cnt_bad;

endmodule

// File: tb/tb_pkt_rx_drain.sv
module tb_pkt_rx_drain;

    logic        clk_156m25 = 1'b0;
    logic        reset_156m25;
    logic        pkt_rx_avail;
    logic        pkt_rx_ren;
    logic        pkt_rx_val;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic        pkt_rx_err;
    logic [63:0] pkt_rx_data;
    logic [2:0]  pkt_rx_mod;
    logic        sum_valid;
    logic        sum_ready;
    logic [13:0] sum_len;
    logic [63:0] sum_xor;
    logic [4:0]  sum_flags;
    logic [31:0] cnt_frames;
    logic [31:0] cnt_bad;

    always #5 clk_156m25 = ~clk_156m25;

    pkt_rx_drain #(
        .MAX_BYTES (1518),
        .MIN_BYTES (64),
        .TIMEOUT   (255)
    ) dut (
        .clk_156m25   (clk_156m25),
        .reset_156m25 (reset_156m25),
        .pkt_rx_avail (pkt_rx_avail),
        .pkt_rx_ren   (pkt_rx_ren),
        .pkt_rx_val   (pkt_rx_val),
        .pkt_rx_sop   (pkt_rx_sop),
        .pkt_rx_eop   (pkt_rx_eop),
        .pkt_rx_err   (pkt_rx_err),
        .pkt_rx_data  (pkt_rx_data),
        .pkt_rx_mod   (pkt_rx_mod),
        .sum_valid    (sum_valid),
        .sum_ready    (sum_ready),
        .sum_len      (sum_len),
        .sum_xor      (sum_xor),
        .sum_flags    (sum_flags),
        .cnt_frames   (cnt_frames),
        .cnt_bad      (cnt_bad)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] fw [0:255];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Raise avail and wait (bounded) for ren; returns cycles waited, 0 on expiry.
    task automatic start_frame(output int cycles);
        cycles = 0;
        pkt_rx_avail = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk_156m25);
            if (pkt_rx_ren) begin
                cycles = i;
                break;
            end
        end
        pkt_rx_avail = 1'b0;
        chk("ren_seen", 64'(cycles != 0), 64'd1);
    endtask

    // Drive n words of fw[] on consecutive cycles; called and returns at a negedge.
    task automatic send_words(input int n, input logic [2:0] mod, input logic err,
                              input bit with_eop);
        for (int i = 0; i < n; i++) begin
            pkt_rx_val  = 1'b1;
            pkt_rx_sop  = (i == 0);
            pkt_rx_eop  = with_eop && (i == n - 1);
            pkt_rx_mod  = (i == n - 1) ? mod : 3'd0;
            pkt_rx_err  = err && (i == n - 1);
            pkt_rx_data = fw[i];
            @(negedge clk_156m25);
        end
        pkt_rx_val  = 1'b0;
        pkt_rx_sop  = 1'b0;
        pkt_rx_eop  = 1'b0;
        pkt_rx_err  = 1'b0;
        pkt_rx_mod  = 3'd0;
        pkt_rx_data = '0;
    endtask

    task automatic wait_sum(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sum_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_156m25);
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic handshake(input string tag);
        sum_ready = 1'b1;
        @(negedge clk_156m25);
        sum_ready = 1'b0;
        chk(tag, 64'(sum_valid), 64'd0);
    endtask

    task automatic load_count8();
        for (int i = 0; i < 8; i++) fw[i] = 64'(i + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  ren_seen;
        bit  unstable;

        reset_156m25 = 1'b1;
        pkt_rx_avail = 1'b0;
        pkt_rx_val   = 1'b0;
        pkt_rx_sop   = 1'b0;
        pkt_rx_eop   = 1'b0;
        pkt_rx_err   = 1'b0;
        pkt_rx_data  = '0;
        pkt_rx_mod   = 3'd0;
        sum_ready    = 1'b0;
        repeat (3) @(negedge clk_156m25);
        reset_156m25 = 1'b0;

        chk("rst_ren",   64'(pkt_rx_ren), 64'd0);
        chk("rst_valid", 64'(sum_valid),  64'd0);
        chk("rst_len",   64'(sum_len),    64'd0);
        chk("rst_xor",   sum_xor,         64'd0);
        chk("rst_flags", 64'(sum_flags),  64'd0);
        chk("rst_cnt",   64'(cnt_frames), 64'd0);

        // 64-byte frame, data 1..8: 1^2^..^8 = 8
        load_count8();
        start_frame(cyc);
        chk("ren_latency", 64'(cyc), 64'd1);
        send_words(8, 3'd0, 1'b0, 1'b1);
        chk("eop_ren_low", 64'(pkt_rx_ren), 64'd0);
        chk("done_no_valid", 64'(sum_valid), 64'd0);
        @(negedge clk_156m25);
        chk("valid_after_done", 64'(sum_valid), 64'd1);
        chk("f64_len",   64'(sum_len),    64'd64);
        chk("f64_xor",   sum_xor,         64'h8);
        chk("f64_flags", 64'(sum_flags),  64'h00);
        chk("f64_cnt",   64'(cnt_frames), 64'd1);
        chk("f64_bad",   64'(cnt_bad),    64'd0);
        handshake("f64_hs");

        // 61-byte frame, eop word all ones masked to 5 bytes
        load_count8();
        fw[7] = 64'hFFFF_FFFF_FFFF_FFFF;
        start_frame(cyc);
        send_words(8, 3'd5, 1'b0, 1'b1);
        wait_sum("f61_valid");
        chk("f61_len",   64'(sum_len),    64'd61);
        chk("f61_xor",   sum_xor,         64'hFFFF_FFFF_FF00_0000);
        chk("f61_flags", 64'(sum_flags),  64'h02);
        chk("f61_cnt",   64'(cnt_frames), 64'd2);
        chk("f61_bad",   64'(cnt_bad),    64'd1);
        handshake("f61_hs");

        // 1519-byte frame with MAC error: 189 full words + 7 bytes
        for (int i = 0; i < 189; i++) fw[i] = '0;
        fw[189] = 64'h0123_4567_89AB_CDEF;
        start_frame(cyc);
        send_words(190, 3'd7, 1'b1, 1'b1);
        wait_sum("giant_valid");
        chk("giant_len",   64'(sum_len),    64'd1519);
        chk("giant_xor",   sum_xor,         64'h0123_4567_89AB_CD00);
        chk("giant_flags", 64'(sum_flags),  64'h05);
        chk("giant_cnt",   64'(cnt_frames), 64'd3);
        chk("giant_bad",   64'(cnt_bad),    64'd2);

        // Back-pressure: summary pending, avail high, ready low for 20 cycles
        pkt_rx_avail = 1'b1;
        ren_seen = 1'b0;
        unstable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_156m25);
            if (pkt_rx_ren) ren_seen = 1'b1;
            if (!sum_valid || sum_len != 14'd1519 || sum_flags != 5'h05) unstable = 1'b1;
        end
        chk("bp_ren_low", 64'(ren_seen), 64'd0);
        chk("bp_stable",  64'(unstable), 64'd0);
        sum_ready = 1'b1;
        @(negedge clk_156m25);
        sum_ready = 1'b0;
        chk("bp_valid_drop", 64'(sum_valid),  64'd0);
        chk("bp_ren_h",      64'(pkt_rx_ren), 64'd0);
        @(negedge clk_156m25);
        chk("bp_ren_h1",     64'(pkt_rx_ren), 64'd1);
        pkt_rx_avail = 1'b0;

        // Stall: sop + 3 words then silence; timeout after 255 idle cycles
        fw[0] = 64'h1; fw[1] = 64'h2; fw[2] = 64'h4; fw[3] = 64'h8;
        send_words(4, 3'd0, 1'b0, 1'b0);
        cyc = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk_156m25);
            if (!pkt_rx_ren) begin
                cyc = i;
                break;
            end
        end
        chk("to_cycles", 64'(cyc), 64'd255);
        wait_sum("to_valid");
        chk("to_len",   64'(sum_len),    64'd32);
        chk("to_xor",   sum_xor,         64'hF);
        chk("to_flags", 64'(sum_flags),  64'h1A);
        chk("to_cnt",   64'(cnt_frames), 64'd4);
        chk("to_bad",   64'(cnt_bad),    64'd3);
        handshake("to_hs");

        // sop while in frame: restart, new frame carries frame_err
        fw[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        fw[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        start_frame(cyc);
        send_words(2, 3'd0, 1'b0, 1'b0);
        load_count8();
        send_words(8, 3'd0, 1'b0, 1'b1);
        wait_sum("rs_valid");
        chk("rs_len",   64'(sum_len),   64'd64);
        chk("rs_xor",   sum_xor,        64'h8);
        chk("rs_flags", 64'(sum_flags), 64'h08);
        chk("rs_bad",   64'(cnt_bad),   64'd4);
        handshake("rs_hs");

        // Reset mid-frame
        fw[0] = 64'h11; fw[1] = 64'h22; fw[2] = 64'h33;
        start_frame(cyc);
        send_words(3, 3'd0, 1'b0, 1'b0);
        reset_156m25 = 1'b1;
        @(negedge clk_156m25);
        reset_156m25 = 1'b0;
        chk("mrst_ren",   64'(pkt_rx_ren), 64'd0);
        chk("mrst_valid", 64'(sum_valid),  64'd0);
        chk("mrst_len",   64'(sum_len),    64'd0);
        chk("mrst_xor",   sum_xor,         64'd0);
        chk("mrst_flags", 64'(sum_flags),  64'd0);
        chk("mrst_cnt",   64'(cnt_frames), 64'd0);
        chk("mrst_bad",   64'(cnt_bad),    64'd0);

        load_count8();
        start_frame(cyc);
        send_words(8, 3'd0, 1'b0, 1'b1);
        wait_sum("post_valid");
        chk("post_len",   64'(sum_len),    64'd64);
        chk("post_xor",   sum_xor,         64'h8);
        chk("post_flags", 64'(sum_flags),  64'h00);
        chk("post_cnt",   64'(cnt_frames), 64'd1);
        handshake("post_hs");

        repeat (3) @(negedge clk_156m25);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
